// File: rtl/mochila_bridge_pkg.sv
// Shared types for the mochila external slave bridge: OBI payloads, FSM states, defaults.
package mochila_bridge_pkg;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = OBI_DW / 8;

  localparam logic [OBI_DW-1:0] DEFAULT_TIMEOUT_RDATA = 32'hBADC_AB1E;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } bridge_state_e;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0] addr;
    logic [OBI_DW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/mochila_bridge_wdt.sv
// Hang watchdog: counts consecutive enabled cycles without a kick; expire_c fires on the last one.
module mochila_bridge_wdt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic kick_i,
  output logic expire_c
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic [WD_W-1:0] wd_cnt_d;

  // A kick in the terminal cycle beats expiry.
  assign expire_c = enable_i && !kick_i && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = wd_cnt_q + WD_W'(1);
    if (!enable_i || kick_i || expire_c) begin
      wd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: rtl/mochila_ext_slave_bridge.sv
// OBI bridge from mochila's external slave port to the target bus, with outstanding cap
// and a watchdog that answers every owed transaction with an error word on a hung target.
module mochila_ext_slave_bridge
  import mochila_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 256,
  parameter logic [31:0] TIMEOUT_RDATA   = DEFAULT_TIMEOUT_RDATA
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  slv_req_i,
  output obi_resp_t slv_resp_o,
  output obi_req_t  mst_req_o,
  input  obi_resp_t mst_resp_i,
  input  logic      clear_timeout_i,
  output logic      timeout_o,
  output logic      busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  bridge_state_e     state_q, state_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic [CNT_W-1:0]  down_cnt_q, down_cnt_d;
  obi_req_t          stage_q, stage_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [OBI_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              timeout_q, timeout_d;

  logic slv_gnt;
  logic slv_hs;
  logic mst_hs;
  logic mst_rvalid;
  logic wd_enable;
  logic wd_kick;
  logic wd_expire;

  // Downstream request is the stage, only presented while running.
  always_comb begin
    mst_req_o     = stage_q;
    mst_req_o.req = stage_q.req && (state_q == ST_RUN);
  end

  assign mst_hs     = mst_req_o.req && mst_resp_i.gnt;
  assign mst_rvalid = mst_resp_i.rvalid;

  // Full-count blocks grant even if a response retires this cycle.
  assign slv_gnt = !rst_i && (state_q == ST_RUN) && (pend_cnt_q < CNT_MAX) &&
                   (!stage_q.req || mst_hs);
  assign slv_hs  = slv_req_i.req && slv_gnt;

  assign slv_resp_o = '{gnt: slv_gnt, rvalid: rsp_valid_q, rdata: rsp_rdata_q};

  assign timeout_o = timeout_q;
  assign busy_o    = (pend_cnt_q != '0) || (down_cnt_q != '0) || (state_q != ST_RUN);

  assign wd_enable = (state_q == ST_RUN);
  assign wd_kick   = (pend_cnt_q == '0) || mst_hs || mst_rvalid;

  mochila_bridge_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable_i(wd_enable),
    .kick_i  (wd_kick),
    .expire_c(wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    pend_cnt_d  = pend_cnt_q;
    down_cnt_d  = down_cnt_q;
    stage_d     = stage_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    timeout_d   = clear_timeout_i ? 1'b0 : timeout_q;

    unique case (state_q)
      ST_RUN: begin
        if (mst_hs) begin
          stage_d.req = 1'b0;
        end
        if (slv_hs) begin
          stage_d     = slv_req_i;
          stage_d.req = 1'b1;
        end
        pend_cnt_d  = pend_cnt_q + CNT_W'(slv_hs) - CNT_W'(mst_rvalid);
        down_cnt_d  = down_cnt_q + CNT_W'(mst_hs) - CNT_W'(mst_rvalid);
        rsp_valid_d = mst_rvalid;
        if (mst_rvalid) begin
          rsp_rdata_d = mst_resp_i.rdata;
        end
        // Abort: the staged request is dropped but stays owed upstream.
        if (wd_expire) begin
          state_d   = ST_FLUSH;
          timeout_d = 1'b1;
          stage_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (pend_cnt_q != '0) begin
          pend_cnt_d = pend_cnt_q - CNT_W'(1);
        end
        if (mst_rvalid && (down_cnt_q != '0)) begin
          down_cnt_d = down_cnt_q - CNT_W'(1);
        end
        if (pend_cnt_q <= CNT_W'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (down_cnt_q == '0) begin
          state_d = ST_RUN;
        end else if (mst_rvalid) begin
          down_cnt_d = down_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Each cycle spent in FLUSH shows one error response on the registered port.
    if (state_d == ST_FLUSH) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = TIMEOUT_RDATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      pend_cnt_q  <= '0;
      down_cnt_q  <= '0;
      stage_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_cnt_q  <= pend_cnt_d;
      down_cnt_q  <= down_cnt_d;
      stage_q     <= stage_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule
